// File: rtl/burst_cache.sv
// burst_cache: direct-mapped write-back, write-allocate cache between a 32-bit CPU port and a 64-bit burst RAM
// Ports: clk, rst_n (async, active-low); CPU side address/data_in/write_enable in, data_out/data_out_ready out;
// RAM side br_cmd/br_cmd_en/br_addr/br_wr_data/br_data_mask out, br_rd_data/br_rd_data_ready/br_busy in.
// Define BURST_CACHE_CLEAR_ON_RESET_EN to invalidate every tag entry after reset (CLEAR state).
module burst_cache #(
  parameter int LINE_IX_BITWIDTH = 10,
  parameter int BURST_RAM_DEPTH_BITWIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [31:0]                         address,
  output logic [31:0]                         data_out,
  output logic                                data_out_ready,
  input  logic [31:0]                         data_in,
  input  logic [3:0]                          write_enable,
  output logic                                br_cmd,
  output logic                                br_cmd_en,
  output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                         br_wr_data,
  output logic [7:0]                          br_data_mask,
  input  logic [63:0]                         br_rd_data,
  input  logic                                br_rd_data_ready,
  input  logic                                br_busy
);
  localparam int LIX = LINE_IX_BITWIDTH;
  localparam int BW = BURST_RAM_DEPTH_BITWIDTH;
  localparam int TW = 27 - LIX;
  localparam int LINES = 1 << LIX;
`ifdef BURST_CACHE_CLEAR_ON_RESET_EN
  typedef enum logic [2:0] {IDLE, WB_CMD, WB_DATA, FILL_CMD, FILL_WAIT, CLEAR} state_t;
  localparam state_t RST_STATE = CLEAR;
  logic [LIX-1:0] clr_q, clr_d;
`else
  typedef enum logic [2:0] {IDLE, WB_CMD, WB_DATA, FILL_CMD, FILL_WAIT} state_t;
  localparam state_t RST_STATE = IDLE;
`endif
  state_t state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic lv_q, lv_d;
  logic [TW+1:0] tag_mem [LINES] = '{default: '0};
  logic [7:0][31:0] data_mem [LINES];
  logic [TW+1:0] tag_q, tag_d, tag_wd;
  logic [7:0][31:0] line_q, line_d, wline;
  logic [TW-1:0] atag_q;
  logic [LIX-1:0] lix, lix_q, taddr;
  logic [2:0] word_q;
  logic [3:0] we_q;
  logic [31:0] din_q;
  logic hit, tag_we, data_we;
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[1:0];
  assign lix = address[LIX+4:5];
  // lv_q marks that tag_q/line_q hold a real lookup (false in the first cycle after reset)
  assign hit = lv_q && tag_q[TW+1] && tag_q[TW-1:0] == atag_q;
  assign data_out = line_q[word_q];
  assign br_data_mask = '0;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    lv_d = 1'b1;
    wline = line_q;
    data_we = 1'b0;
    tag_we = 1'b0;
    tag_wd = {2'b11, tag_q[TW-1:0]};
    taddr = lix_q;
    br_cmd = 1'b0;
    br_cmd_en = 1'b0;
    br_addr = BW'({atag_q, lix_q, 2'b00});
    br_wr_data = '0;
    data_out_ready = 1'b0;
`ifdef BURST_CACHE_CLEAR_ON_RESET_EN
    clr_d = clr_q;
`endif
    case (state_q)
      IDLE: begin
        data_out_ready = hit;
        if (hit && |we_q) begin
          for (int b = 0; b < 4; b++)
            if (we_q[b]) wline[word_q][8*b +: 8] = din_q[8*b +: 8];
          data_we = 1'b1;
          tag_we = 1'b1;
        end
        if (lv_q && !hit) state_d = (tag_q[TW+1] && tag_q[TW]) ? WB_CMD : FILL_CMD;
      end
      WB_CMD: begin
        br_cmd = 1'b1;
        br_cmd_en = !br_busy;
        br_addr = BW'({tag_q[TW-1:0], lix_q, 2'b00});
        beat_d = 2'd0;
        if (!br_busy) state_d = WB_DATA;
      end
      WB_DATA: begin
        br_wr_data = {line_q[{beat_q, 1'b1}], line_q[{beat_q, 1'b0}]};
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = FILL_CMD;
      end
      FILL_CMD: begin
        br_cmd_en = !br_busy;
        beat_d = 2'd0;
        if (!br_busy) state_d = FILL_WAIT;
      end
      FILL_WAIT: if (br_rd_data_ready) begin
        // line_q doubles as the fill buffer; the array is only written after the last beat
        wline[{beat_q, 1'b0}] = br_rd_data[31:0];
        wline[{beat_q, 1'b1}] = br_rd_data[63:32];
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          data_we = 1'b1;
          tag_we = 1'b1;
          tag_wd = {2'b10, atag_q};
          state_d = IDLE;
        end
      end
`ifdef BURST_CACHE_CLEAR_ON_RESET_EN
      CLEAR: begin
        lv_d = 1'b0;
        tag_we = 1'b1;
        tag_wd = '0;
        taddr = clr_q;
        clr_d = clr_q + 1'b1;
        if (&clr_q) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // write-first forwarding so the lookup after a write or fill sees the new contents
    line_d = (state_q == FILL_WAIT || (data_we && lix == lix_q)) ? wline : data_mem[lix];
    tag_d = (tag_we && taddr == lix) ? tag_wd : tag_mem[lix];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      beat_q <= '0;
      lv_q <= 1'b0;
`ifdef BURST_CACHE_CLEAR_ON_RESET_EN
      clr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      lv_q <= lv_d;
`ifdef BURST_CACHE_CLEAR_ON_RESET_EN
      clr_q <= clr_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[taddr] <= tag_wd;
    if (data_we) data_mem[lix_q] <= wline;
    tag_q <= tag_d;
    line_q <= line_d;
    atag_q <= address[31:LIX+5];
    lix_q <= lix;
    word_q <= address[4:2];
    we_q <= write_enable;
    din_q <= data_in;
  end
endmodule

// File: tb/tb_burst_cache.sv
// tb_burst_cache: directed vector bench for burst_cache with a behavioural burst RAM
module tb_burst_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] address = 32'd16;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [3:0] write_enable = '0;
  logic data_out_ready, br_cmd, br_cmd_en;
  logic br_rd_data_ready = 1'b0;
  logic br_busy = 1'b1;
  logic [3:0] br_addr;
  logic [63:0] br_wr_data;
  logic [63:0] br_rd_data = '0;
  logic [7:0] br_data_mask;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] exp;
    int          lat;
    int          cmds;
    logic [3:0]  baddr;
  } vec_t;

  always #5 clk = ~clk;

  burst_cache #(.LINE_IX_BITWIDTH(1), .BURST_RAM_DEPTH_BITWIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_out(data_out),
    .data_out_ready(data_out_ready), .data_in(data_in), .write_enable(write_enable),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_ready(br_rd_data_ready),
    .br_busy(br_busy)
  );

  // burst RAM model: read data 2 cycles after the command, write beats in the 4 cycles after it
  logic [63:0] ram [16];
  logic [63:0] wb_log [4];
  logic [3:0] rd_ix, wr_ix, last_addr, wb_addr;
  logic last_cmd = 1'b0;
  int cmd_cnt = 0, wb_cnt = 0, rd_dly = 0, rd_beat = 0, wr_left = 0, beat_shown = -1;
  logic rd_on = 1'b0;

  always @(negedge clk) begin
    br_rd_data_ready = 1'b0;
    if (!rst_n) begin
      rd_on = 1'b0;
      wr_left = 0;
    end else begin
      if (wr_left > 0) begin
        ram[wr_ix] = br_wr_data;
        wb_log[4 - wr_left] = br_wr_data;
        wr_ix = wr_ix + 4'd1;
        wr_left--;
      end
      if (rd_on) begin
        if (rd_dly > 0) rd_dly--;
        else begin
          br_rd_data = ram[rd_ix];
          br_rd_data_ready = 1'b1;
          beat_shown = rd_beat;
          rd_ix = rd_ix + 4'd1;
          rd_beat++;
          if (rd_beat == 4) rd_on = 1'b0;
        end
      end
      if (br_cmd_en) begin
        cmd_cnt++;
        last_cmd = br_cmd;
        last_addr = br_addr;
        if (br_cmd) begin
          wr_left = 4;
          wr_ix = br_addr;
          wb_addr = br_addr;
          wb_cnt++;
        end else begin
          rd_on = 1'b1;
          rd_dly = 2;
          rd_ix = br_addr;
          rd_beat = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        output int n, output logic [31:0] q, output int c);
    int c0;
    c0 = cmd_cnt;
    address = a;
    write_enable = w;
    data_in = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!data_out_ready && n < 60);
    q = data_out;
    c = cmd_cnt - c0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v [12];
    int n, c;
    logic [31:0] q;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    ram[1] = {32'h9D8E2F17, 32'hAB4C3E6F};
    ram[2] = {32'h00000000, 32'hD5B8A9C4};
    ram[4] = {32'h00000000, 32'h2F5E3C7A};
    v[0]  = '{32'd8,  4'b0000, 32'h0,        32'hAB4C3E6F, 1,  0, 4'd0};
    v[1]  = '{32'd12, 4'b0000, 32'h0,        32'h9D8E2F17, 1,  0, 4'd0};
    v[2]  = '{32'd32, 4'b0000, 32'h0,        32'h2F5E3C7A, 9,  1, 4'd4};
    v[3]  = '{32'd8,  4'b0001, 32'h000000AD, 32'h0,        1,  0, 4'd0};
    v[4]  = '{32'd8,  4'b0000, 32'h0,        32'hAB4C3EAD, 1,  0, 4'd0};
    v[5]  = '{32'd8,  4'b0011, 32'h00008765, 32'h0,        1,  0, 4'd0};
    v[6]  = '{32'd8,  4'b0000, 32'h0,        32'hAB4C8765, 1,  0, 4'd0};
    v[7]  = '{32'd8,  4'b1100, 32'hFEEF0000, 32'h0,        1,  0, 4'd0};
    v[8]  = '{32'd8,  4'b0000, 32'h0,        32'hFEEF8765, 1,  0, 4'd0};
    v[9]  = '{32'd72, 4'b0000, 32'h0,        32'h00000000, 14, 2, 4'd8};
    v[10] = '{32'd8,  4'b0000, 32'h0,        32'hFEEF8765, 9,  1, 4'd0};
    v[11] = '{32'd32, 4'b0000, 32'h0,        32'h2F5E3C7A, 1,  0, 4'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", data_out_ready, 0);
    chk("rst_cmd_en", br_cmd_en, 0);
    chk("rst_cmd", br_cmd, 0);
    chk("rst_wr_data", br_wr_data, 0);
    chk("rst_mask", br_data_mask, 0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_no_cmd", cmd_cnt, 0);
    chk("busy_no_ready", data_out_ready, 0);
    br_busy = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!data_out_ready && n < 60);
    chk("miss16_ready", data_out_ready, 1);
    chk("miss16_data", data_out, 32'hD5B8A9C4);
    chk("miss16_cmds", cmd_cnt, 1);
    chk("miss16_addr", last_addr, 0);
    chk("miss16_type", last_cmd, 0);

    foreach (v[i]) begin
      run_op(v[i].a, v[i].we, v[i].din, n, q, c);
      chk($sformatf("v%0d_latency", i), n, v[i].lat);
      chk($sformatf("v%0d_cmds", i), c, v[i].cmds);
      if (v[i].we == 4'b0000) chk($sformatf("v%0d_data", i), q, v[i].exp);
      if (v[i].cmds > 0) chk($sformatf("v%0d_br_addr", i), last_addr, v[i].baddr);
    end
    chk("wb_count", wb_cnt, 1);
    chk("wb_addr", wb_addr, 0);
    chk("wb_beat1", wb_log[1], {32'h9D8E2F17, 32'hFEEF8765});

    address = 32'd96;
    write_enable = 4'b0000;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(br_rd_data_ready && beat_shown == 2) && n < 60);
    chk("mf_beat2_reached", beat_shown, 2);
    chk("mf_fill_addr", last_addr, 12);
    rst_n = 1'b0;
    #1;
    chk("mf_rst_ready", data_out_ready, 0);
    chk("mf_rst_cmd_en", br_cmd_en, 0);
    chk("mf_rst_cmd", br_cmd, 0);
    chk("mf_rst_wr_data", br_wr_data, 0);
    address = 32'd32;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(32'd32, 4'b0000, 32'h0, n, q, c);
    chk("mf_old_latency", n, 1);
    chk("mf_old_cmds", c, 0);
    chk("mf_old_data", q, 32'h2F5E3C7A);
    run_op(32'd96, 4'b0000, 32'h0, n, q, c);
    chk("mf_refill_latency", n, 9);
    chk("mf_refill_cmds", c, 1);
    chk("mf_refill_addr", last_addr, 12);
    chk("mf_refill_data", q, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/burst_cache.md
Name: burst_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between a 32-bit byte-addressed CPU port and a 64-bit burst RAM controller (br_ port group).
- Each line is 32 bytes: eight 32-bit words, filled or evicted by one 4-beat 64-bit burst.
- Tag and data arrays are single-cycle synchronous BRAMs, so a hit returns data one clock after the address is presented.

Parameters:
- LINE_IX_BITWIDTH, 10, log2 of the number of lines.
- BURST_RAM_DEPTH_BITWIDTH, 4, width of br_addr in 8-byte words.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- address  in  32  byte address; bits [1:0] ignored; held stable until data_out_ready
- data_out  out  32  read data for address
- data_out_ready  out  1  operation at address complete / data_out valid
- data_in  in  32  write data
- write_enable  in  4  byte enables (bit0 = bits 7:0); 0 means read
- br_cmd  out  1  0 read, 1 write
- br_cmd_en  out  1  command and address valid, one-cycle pulse
- br_addr  out  BURST_RAM_DEPTH_BITWIDTH  line start in 8-byte words; low 2 bits are 0
- br_wr_data  out  64  write beat
- br_data_mask  out  8  constant 0
- br_rd_data  in  64  read beat
- br_rd_data_ready  in  1  br_rd_data valid
- br_busy  in  1  RAM cannot accept a command

Behaviour:
- Address split:
  - word = address[4:2]
  - line_ix = address[LINE_IX_BITWIDTH+4:5]
  - tag = address[31:LINE_IX_BITWIDTH+5]
- Tag entry = {valid, dirty, tag}.
- Reset: FSM returns to IDLE; br_cmd_en = 0; br_cmd = 0; br_wr_data = 0; data_out_ready = 0.
- Array contents are not cleared by reset. Tag RAM is initialised to zero at configuration.
- IDLE lookup:
  - BRAMs are read at line_ix every cycle.
  - hit = valid && stored tag == current address tag.
  - data_out = word selected by registered word index.
  - data_out_ready = hit && state == IDLE, combinational on the registered lookup.
- Read hit latency: 1 clock. Address changes every cycle are allowed while hits continue.
- Write hit, write_enable != 0:
  - Enabled bytes of the addressed word are written at the edge ending the cycle in which hit is asserted.
  - The dirty bit is set.
  - A read of the same word on the next cycle returns the merged value.
- Miss, any operation, with line valid and dirty: go to WB_CMD.
  - Wait for !br_busy, then pulse br_cmd_en with br_cmd = 1 and br_addr of the old line ({old tag, line_ix, 2'b00} truncated).
  - Drive 4 beats of br_wr_data on consecutive cycles. Beat k = {word 2k+1, word 2k}.
  - Then go to FILL_CMD.
- Miss with line clean or invalid: go to FILL_CMD.
  - Wait for !br_busy, then pulse br_cmd_en with br_cmd = 0 and the new line address.
- FILL_WAIT:
  - On each br_rd_data_ready, beat k writes word 2k (low half) and word 2k+1 (high half).
  - After beat 3, write the tag entry {1, 0, new tag} and return to IDLE.
  - The next cycle's lookup hits; a pending write then completes as a write hit.
- data_out_ready stays 0 for the whole miss sequence. Minimum miss penalty is command cycle + RAM latency + 4 beats + 1.
- br_busy high after reset (RAM initialising): no command is issued until it drops.
- Reset mid-miss: sequence aborted and the tag is not updated, so the line remains as before. A reset during write-back leaves that RAM line partially written. This is accepted.
- Address or write_enable changing during a miss: undefined. The caller must hold them.

Optional Feature:
- Macro: BURST_CACHE_CLEAR_ON_RESET_EN.
- Defined: after rst_n deasserts, the FSM enters CLEAR and writes tag entry 0 to every line, one per clock, for 2^LINE_IX_BITWIDTH cycles. data_out_ready stays 0 during CLEAR, and no br command is issued.
- Undefined: no CLEAR state; the tag RAM relies on its configuration-time zero initialisation.

Test Plan:
RAM image for all scenarios (32-bit little-endian words at byte addresses): 8 = 0xAB4C3E6F, 12 = 0x9D8E2F17, 16 = 0xD5B8A9C4, 32 = 0x2F5E3C7A.
- Read miss: after br_busy drops, read address 16 -> one read burst at br_addr 0, then data_out = 0xD5B8A9C4 with data_out_ready.
- Read hits: addr 8, then 12 on consecutive cycles -> 0xAB4C3E6F, then 0x9D8E2F17, each one clock later with ready = 1; no br_cmd_en.
- Invalid-line miss: addr 32 -> ready = 0 the next cycle, burst at br_addr 4, then 0x2F5E3C7A with ready.
- Byte-enable writes to addr 8:
  - data_in 0x000000AD, write_enable 0001 -> read 0xAB4C3EAD
  - data_in 0x00008765, write_enable 0011 -> read 0xAB4C8765
  - data_in 0xFEEF0000, write_enable 1100 -> read 0xFEEF8765
- Eviction, LINE_IX_BITWIDTH = 1: dirty addr 8, then read addr 72 -> write burst at br_addr 0 with beat 1 = {0x9D8E2F17, 0xFEEF8765}, then read burst at br_addr 8. Re-reading addr 8 returns 0xFEEF8765.
- Reset mid-fill: assert rst_n low during beat 2 -> outputs at reset values, tag unchanged; re-issuing the read completes a fresh burst.
